// File: rtl/bus_transfer_engine.sv
// bus_transfer_engine
//   Sequenced replacement for a combinational priority bus mux. A control
//   unit issues one transfer at a time (source index plus destination mask).
//   The engine drives BUS from the chosen source. On the next slow-clock
//   strobe it pulses the destination load enables, then reports completion
//   with a one-cycle XFER_DONE. Malformed requests set sticky error flags.
//   Completed transfers are counted.
//
// Ports
//   CLK, ARST_L       clock, asynchronous active-low reset
//   SLOW_CLOCK_STRB   one-cycle enable; the sequence only advances on it
//   SRC_DATA          flattened sources, source i at [i*DATA_W +: DATA_W]
//   XFER_REQ/SRC/DST  transfer request, source index, destination mask
//   CLR_ERR           clears ERR_SRC / ERR_DST on the next edge
//   XFER_BUSY         high while a transfer is driving the bus
//   XFER_DONE         one-cycle completion pulse
//   BUS               shared bus value
//   DST_LOAD          per-destination load enables (strobe-qualified)
//   ERR_SRC/ERR_DST   sticky: out-of-range source / empty destination mask
//   XFER_CNT          completed-transfer count, wraps on overflow
module bus_transfer_engine #(
  parameter int DATA_W   = 16,
  parameter int N_SRC    = 8,
  parameter int SRC_W    = 3,
  parameter int N_DST    = 8,
  parameter int HOLD_BUS = 0,
  parameter int CNT_W    = 8
) (
  input  logic                    CLK,
  input  logic                    ARST_L,
  input  logic                    SLOW_CLOCK_STRB,
  input  logic [N_SRC*DATA_W-1:0] SRC_DATA,
  input  logic                    XFER_REQ,
  input  logic [SRC_W-1:0]        XFER_SRC,
  input  logic [N_DST-1:0]        XFER_DST,
  input  logic                    CLR_ERR,
  output logic                    XFER_BUSY,
  output logic                    XFER_DONE,
  output logic [DATA_W-1:0]       BUS,
  output logic [N_DST-1:0]        DST_LOAD,
  output logic                    ERR_SRC,
  output logic                    ERR_DST,
  output logic [CNT_W-1:0]        XFER_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One extra bit so N_SRC == 2**SRC_W still compares correctly.
  localparam logic [SRC_W:0] N_SRC_L = (SRC_W + 1)'(N_SRC);

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [N_DST-1:0]    dst_q, dst_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_src_q, err_src_d;
  logic                err_dst_q, err_dst_d;

  logic                set_err_src;
  logic                set_err_dst;
  logic                src_oob;
  logic                bus_drive;
  logic [DATA_W-1:0]   src_word;

  assign src_oob = ({1'b0, XFER_SRC} >= N_SRC_L);

  // Loop-based select keeps indices inside SRC_DATA even when
  // N_SRC < 2**SRC_W; src_q is only ever loaded with in-range values.
  always_comb begin
    src_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_q == SRC_W'(i)) src_word = SRC_DATA[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    set_err_src = 1'b0;
    set_err_dst = 1'b0;
    bus_drive   = 1'b0;
    XFER_BUSY   = 1'b0;
    XFER_DONE   = 1'b0;
    DST_LOAD    = '0;

    case (state_q)
      ST_IDLE: begin
        if (XFER_REQ && SLOW_CLOCK_STRB) begin
          // Source fault takes priority over an empty mask.
          if (src_oob) begin
            set_err_src = 1'b1;
          end else if (XFER_DST == '0) begin
            set_err_dst = 1'b1;
          end else begin
            src_d   = XFER_SRC;
            dst_d   = XFER_DST;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        XFER_BUSY = 1'b1;
        bus_drive = 1'b1;
        if (SLOW_CLOCK_STRB) begin
          DST_LOAD = dst_q;
          hold_d   = src_word;
          cnt_d    = cnt_q + 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        XFER_DONE = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set beats clear when both happen in the same cycle.
    err_src_d = set_err_src | (err_src_q & ~CLR_ERR);
    err_dst_d = set_err_dst | (err_dst_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      err_src_q <= 1'b0;
      err_dst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      err_src_q <= err_src_d;
      err_dst_q <= err_dst_d;
    end
  end

  assign BUS      = bus_drive ? src_word : ((HOLD_BUS != 0) ? hold_q : '0);
  assign ERR_SRC  = err_src_q;
  assign ERR_DST  = err_dst_q;
  assign XFER_CNT = cnt_q;

endmodule

// File: tb/tb_bus_transfer_engine.sv
// Testbench for bus_transfer_engine. Two instances share clock, reset,
// strobe and source data:
//   A: N_SRC=6, HOLD_BUS=1, CNT_W=8
//   B: N_SRC=8, HOLD_BUS=0, CNT_W=2
// A transaction-level reference model predicts every output each cycle.
module tb_bus_transfer_engine;

  logic         clk;
  logic         arst_l;
  logic         strb;
  logic [127:0] src_data;
  logic         req  [2];
  logic [2:0]   xsrc [2];
  logic [7:0]   xdst [2];
  logic         clr  [2];
  logic         busy [2];
  logic         done [2];
  logic [15:0]  bus  [2];
  logic [7:0]   load [2];
  logic         esrc [2];
  logic         edst [2];
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int n_vec  = 0;
  int n_fail = 0;
  int done_seen [2] = '{0, 0};

  bus_transfer_engine #(.DATA_W(16), .N_SRC(6), .SRC_W(3), .N_DST(8),
                        .HOLD_BUS(1), .CNT_W(8)) dut_a (
    .CLK(clk), .ARST_L(arst_l), .SLOW_CLOCK_STRB(strb),
    .SRC_DATA(src_data[95:0]), .XFER_REQ(req[0]), .XFER_SRC(xsrc[0]),
    .XFER_DST(xdst[0]), .CLR_ERR(clr[0]), .XFER_BUSY(busy[0]),
    .XFER_DONE(done[0]), .BUS(bus[0]), .DST_LOAD(load[0]),
    .ERR_SRC(esrc[0]), .ERR_DST(edst[0]), .XFER_CNT(cnt_a));

  bus_transfer_engine #(.DATA_W(16), .N_SRC(8), .SRC_W(3), .N_DST(8),
                        .HOLD_BUS(0), .CNT_W(2)) dut_b (
    .CLK(clk), .ARST_L(arst_l), .SLOW_CLOCK_STRB(strb),
    .SRC_DATA(src_data), .XFER_REQ(req[1]), .XFER_SRC(xsrc[1]),
    .XFER_DST(xdst[1]), .CLR_ERR(clr[1]), .XFER_BUSY(busy[1]),
    .XFER_DONE(done[1]), .BUS(bus[1]), .DST_LOAD(load[1]),
    .ERR_SRC(esrc[1]), .ERR_DST(edst[1]), .XFER_CNT(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int NS [2] = '{6, 8};
  int HB [2] = '{1, 0};
  int CM [2] = '{256, 4};

  bit          m_pend [2];   // accepted transfer waiting for its load strobe
  bit          m_done [2];   // completion pulse owed this cycle
  logic [2:0]  m_src  [2];
  logic [7:0]  m_dst  [2];
  logic [15:0] m_hold [2];
  int          m_cnt  [2];
  bit          m_esrc [2];
  bit          m_edst [2];

  function automatic logic [15:0] word(input logic [2:0] s);
    return src_data[int'(s)*16 +: 16];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_done[i] = 0; m_src[i] = '0; m_dst[i] = '0;
      m_hold[i] = '0; m_cnt[i] = 0; m_esrc[i] = 0; m_edst[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit set_s = 0;
      bit set_d = 0;
      if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_pend[i]) begin
        if (strb) begin
          m_hold[i] = word(m_src[i]);
          m_cnt[i]  = (m_cnt[i] + 1) % CM[i];
          m_pend[i] = 0;
          m_done[i] = 1;
        end
      end else if (req[i] && strb) begin
        if (int'(xsrc[i]) >= NS[i]) set_s = 1;
        else if (xdst[i] == 8'h00) set_d = 1;
        else begin
          m_pend[i] = 1; m_src[i] = xsrc[i]; m_dst[i] = xdst[i];
        end
      end
      m_esrc[i] = set_s ? 1'b1 : (clr[i] ? 1'b0 : m_esrc[i]);
      m_edst[i] = set_d ? 1'b1 : (clr[i] ? 1'b0 : m_edst[i]);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] e_bus;
      logic [7:0]  e_load;
      int          a_cnt;
      e_bus  = m_pend[i] ? word(m_src[i]) : ((HB[i] != 0) ? m_hold[i] : 16'h0);
      e_load = (m_pend[i] && strb) ? m_dst[i] : 8'h00;
      a_cnt  = (i == 0) ? int'(cnt_a) : int'(cnt_b);
      if (done[i]) done_seen[i]++;
      n_vec++;
      if (busy[i] !== m_pend[i] || done[i] !== m_done[i] || bus[i] !== e_bus ||
          load[i] !== e_load || esrc[i] !== m_esrc[i] || edst[i] !== m_edst[i] ||
          a_cnt != m_cnt[i]) begin
        n_fail++;
        $display("FAIL model[%0d] t=%0t got busy=%b done=%b bus=%h load=%h esrc=%b edst=%b cnt=%0d want busy=%b done=%b bus=%h load=%h esrc=%b edst=%b cnt=%0d",
                 i, $time, busy[i], done[i], bus[i], load[i], esrc[i], edst[i], a_cnt,
                 m_pend[i], m_done[i], e_bus, e_load, m_esrc[i], m_edst[i], m_cnt[i]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    arst_l = 1'b0;
    model_reset();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    arst_l = 1'b1;
  endtask

  task automatic set_in(input int i, input logic r, input logic [2:0] s,
                        input logic [7:0] d, input logic c);
    req[i] = r; xsrc[i] = s; xdst[i] = d; clr[i] = c;
  endtask

  // ---------------- directed table (expectations for instance A) ----------------
  typedef struct {
    logic        req;
    logic [2:0]  src;
    logic [7:0]  dst;
    logic        clr;
    logic        strb;
    logic [15:0] d2;
    logic        busy;
    logic        done;
    logic [7:0]  load;
    logic [15:0] bus;
    int          cnt;
    logic        esrc;
    logic        edst;
  } vec_t;

  vec_t tab [15];

  task automatic check_tab(input int k, input vec_t v);
    n_vec++;
    if (busy[0] !== v.busy || done[0] !== v.done || load[0] !== v.load ||
        bus[0] !== v.bus || int'(cnt_a) != v.cnt || esrc[0] !== v.esrc ||
        edst[0] !== v.edst) begin
      n_fail++;
      $display("FAIL table[%0d] got busy=%b done=%b load=%h bus=%h cnt=%0d esrc=%b edst=%b want busy=%b done=%b load=%h bus=%h cnt=%0d esrc=%b edst=%b",
               k, busy[0], done[0], load[0], bus[0], cnt_a, esrc[0], edst[0],
               v.busy, v.done, v.load, v.bus, v.cnt, v.esrc, v.edst);
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int d0;
    int cnt_exp [5] = '{1, 2, 3, 0, 1};

    //            req src   dst    clr strb d2       busy done load   bus      cnt esrc edst
    tab[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 3'd2, 8'h05, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 8'h00, 16'hBEEF, 0, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 8'h00, 16'hBEEF, 0, 1'b0, 1'b0};
    tab[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h05, 16'hBEEF, 0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};
    tab[7]  = '{1'b1, 3'd7, 8'h01, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};
    tab[8]  = '{1'b1, 3'd7, 8'h00, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b1, 1'b0};
    tab[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b1, 1'b0};
    tab[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};
    tab[11] = '{1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};
    tab[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b1};
    tab[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b1};
    tab[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 16'hBEEF, 1, 1'b0, 1'b0};

    arst_l   = 1'b0;
    strb     = 1'b0;
    src_data = {$urandom, $urandom, $urandom, $urandom};
    src_data[2*16 +: 16] = 16'hBEEF;
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 3'd0, 8'h00, 1'b0);
    #1;
    do_reset();

    // Directed table; both instances see the same request stream.
    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 2; i++) set_in(i, tab[k].req, tab[k].src, tab[k].dst, tab[k].clr);
      strb = tab[k].strb;
      src_data[2*16 +: 16] = tab[k].d2;
      @(negedge clk);
      check_model();
      check_tab(k, tab[k]);
      @(posedge clk);
      model_step();
      #1;
    end
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 3'd0, 8'h00, 1'b0);
    strb = 1'b0;
    step();

    // A request pulsed during DRIVE is ignored: exactly one completion.
    d0 = done_seen[0];
    strb = 1'b1; set_in(0, 1'b1, 3'd1, 8'h30, 1'b0); step();
    strb = 1'b0; set_in(0, 1'b1, 3'd4, 8'h03, 1'b0); step();
    set_in(0, 1'b0, 3'd0, 8'h00, 1'b0); step();
    strb = 1'b1; step();
    strb = 1'b0;
    for (int k = 0; k < 4; k++) step();
    expect_eq("one_done_per_xfer", done_seen[0] - d0, 1);

    // Reset asserted mid-DRIVE while DST_LOAD is active.
    strb = 1'b1; set_in(0, 1'b1, 3'd3, 8'hFF, 1'b0); step();
    set_in(0, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    check_model();
    #2;
    arst_l = 1'b0;
    model_reset();
    #1;
    expect_eq("rst_dst_load", int'(load[0]), 0);
    expect_eq("rst_busy", int'(busy[0]), 0);
    expect_eq("rst_bus", int'(bus[0]), 0);
    expect_eq("rst_cnt", int'(cnt_a), 0);
    @(posedge clk);
    #1;
    arst_l = 1'b1;
    d0 = done_seen[0];
    for (int k = 0; k < 4; k++) step();
    expect_eq("rst_no_done", done_seen[0] - d0, 0);

    // Strobe tied high, five back-to-back transfers on the 2-bit counter.
    do_reset();
    strb = 1'b1;
    set_in(1, 1'b1, 3'd5, 8'h81, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(); step(); step();
      expect_eq($sformatf("cnt_wrap[%0d]", k), int'(cnt_b), cnt_exp[k]);
    end
    set_in(1, 1'b0, 3'd0, 8'h00, 1'b0);
    strb = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      strb = ($urandom_range(0, 2) == 0) || (n % 400 < 40);
      for (int i = 0; i < 2; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        set_in(i, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), d,
               ($urandom_range(0, 9) == 0));
      end
      if ($urandom_range(0, 3) == 0) src_data[$urandom_range(0, 7)*16 +: 16] = 16'($urandom);
      if (n == 1500) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
